// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPRITE_W x SPRITE_H ROM and emits one clipped, keyed pixel write per clock.
// Latency: first write two cycles after start is accepted; done pulses N+2 cycles after accept.
module sprite_blitter #(
    parameter int SPRITE_W           = 32,
    parameter int SPRITE_H           = 64,
    parameter int X_W                = 9,
    parameter int Y_W                = 8,
    parameter int COLOUR_W           = 3,
    parameter int SCREEN_W           = 320,
    parameter int SCREEN_H           = 240,
    parameter int TRANSPARENT_EN     = 1,
    parameter int TRANSPARENT_COLOUR = 0,
    localparam int CW                = $clog2(SPRITE_W),
    localparam int RW                = $clog2(SPRITE_H),
    localparam int ADDR_W            = CW + RW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic                flip_h,
    input  logic                erase,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                writeEn,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic                r_flip;
    logic                r_erase;
    logic [COLOUR_W-1:0] r_bg;
    logic                r_vld;
    logic [X_W:0]        r_sx;
    logic [Y_W:0]        r_sy;

    logic                w_accept;
    logic                w_last;
    logic [CW-1:0]       w_col_off;
    logic [X_W:0]        w_sx;
    logic [Y_W:0]        w_sy;
    logic                w_keyed;
    logic                w_on_screen;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (&r_col) && (&r_row);
    // Mirroring a power-of-two column index is just its bitwise complement.
    assign w_col_off = r_flip ? ~r_col : r_col;
    assign w_sx      = {1'b0, r_x0} + (X_W+1)'(w_col_off);
    assign w_sy      = {1'b0, r_y0} + (Y_W+1)'(r_row);

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        rom_addr = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                rom_addr = {r_row, r_col};
                if (w_last) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_DONE;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_flip  <= 1'b0;
            r_erase <= 1'b0;
            r_bg    <= '0;
            r_vld   <= 1'b0;
            r_sx    <= '0;
            r_sy    <= '0;
        end else begin
            r_state <= w_next;
            r_vld   <= (r_state == S_RUN);
            if (w_accept) begin
                r_x0    <= x_in;
                r_y0    <= y_in;
                r_flip  <= flip_h;
                r_erase <= erase;
                r_bg    <= bg_colour;
                r_col   <= '0;
                r_row   <= '0;
            end else if (r_state == S_RUN) begin
                {r_row, r_col} <= {r_row, r_col} + ADDR_W'(1);
            end
            if (r_state == S_RUN) begin
                r_sx <= w_sx;
                r_sy <= w_sy;
            end
        end
    end

    // The pixel stage lines up with rom_data, so keying and colour select are combinational here.
    assign w_keyed     = (TRANSPARENT_EN != 0) && !r_erase &&
                         (rom_data == COLOUR_W'(TRANSPARENT_COLOUR));
    assign w_on_screen = (r_sx < (X_W+1)'(SCREEN_W)) && (r_sy < (Y_W+1)'(SCREEN_H));
    assign writeEn     = r_vld && w_on_screen && !w_keyed;
    assign colour_out  = r_vld ? (r_erase ? r_bg : rom_data) : '0;
    assign x_out       = r_sx[X_W-1:0];
    assign y_out       = r_sy[Y_W-1:0];

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite drawing engine for the VGA graphics path. On a start pulse it latches a screen origin and mode, walks a SPRITE_W × SPRITE_H sprite stored in an external synchronous ROM, and emits one pixel write per clock to the frame-buffer writer. Compared with the earlier fixed 32×64, two-cycles-per-pixel graphing units, it is generic in size and colour depth and adds horizontal flip, transparency keying, erase mode and screen-edge clipping. One instance per sprite ROM; outputs feed the VGA adapter write mux.

## Interface
- SPRITE_W, 32: sprite width in pixels; must be a power of 2.
- SPRITE_H, 64: sprite height in pixels; must be a power of 2.
- X_W, 9: screen x coordinate width.
- Y_W, 8: screen y coordinate width.
- COLOUR_W, 3: pixel colour width.
- SCREEN_W, 320: visible width; pixels with x ≥ SCREEN_W are clipped.
- SCREEN_H, 240: visible height; pixels with y ≥ SCREEN_H are clipped.
- TRANSPARENT_EN, 1: enables colour-key skipping.
- TRANSPARENT_COLOUR, 0: key colour.
- ADDR_W is a localparam, equal to log2(SPRITE_W) + log2(SPRITE_H).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  draw request; sampled only in IDLE.
- x_in  in  X_W  sprite origin x (left column); latched on accept.
- y_in  in  Y_W  sprite origin y (top row); latched on accept.
- flip_h  in  1  mirror the sprite horizontally; latched on accept.
- erase  in  1  write bg_colour instead of ROM data; latched on accept.
- bg_colour  in  COLOUR_W  erase colour; latched on accept.
- rom_addr  out  ADDR_W  ROM address, {row, col}.
- rom_data  in  COLOUR_W  ROM output; valid one cycle after rom_addr.
- x_out  out  X_W  pixel x.
- y_out  out  Y_W  pixel y.
- colour_out  out  COLOUR_W  pixel colour.
- writeEn  out  1  pixel write strobe.
- busy  out  1  high from accept until done.
- done  out  1  single-cycle completion pulse.

## Operation
- N = SPRITE_W·SPRITE_H.
- The state machine has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - busy = 0.
  - On start = 1: latch the origin and mode inputs, clear col/row, and go to RUN.
- RUN:
  - Present rom_addr = {row, col}, combinationally from the counters.
  - col increments each cycle; when col wraps, row increments.
  - After the address for (SPRITE_W−1, SPRITE_H−1), go to DRAIN.
- DRAIN: one cycle, in which the last ROM word returns. Then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Pixel stage: a one-stage pipeline carries valid, sx and sy so they align with rom_data.
  - sx = x0 + (flip_h ? SPRITE_W−1−col : col), computed at X_W+1 bits.
  - sy = y0 + row, computed at Y_W+1 bits. There is no wrap-around.
  - x_out = sx[X_W−1:0] and y_out = sy[Y_W−1:0], registered.
  - colour_out = erase ? bg_colour : rom_data while the stage is valid, otherwise 0.
  - writeEn = valid && sx < SCREEN_W && sy < SCREEN_H && !(TRANSPARENT_EN && !erase && rom_data == TRANSPARENT_COLOUR).
- The ROM address is independent of flip_h; flip affects screen x only.
- Clipped and transparent pixels still consume their cycle, so the draw time is constant.
- start is ignored in RUN, DRAIN and DONE, including on the cycle done is high.
- Reset values: state IDLE, busy 0, done 0, writeEn 0, x_out 0, y_out 0, rom_addr 0, colour_out 0, all latches 0.
- Reset mid-draw: the next cycle is IDLE with all outputs at reset values. No further writes occur and done is not pulsed.

## Timing
- Cycle 0: start accepted.
- busy is high in cycles 1 through N+2.
- rom_addr for pixel k is presented in cycle k+1.
- writeEn for pixel k is in cycle k+2. One pixel per clock; the writes span cycles 2 through N+1.
- done is high in cycle N+2. The block is back in IDLE in cycle N+3 and can accept the next start there.
- With defaults (N = 2048), start-to-done is 2050 cycles, versus about 4100 for the previous generation.
- rom_addr is 0 outside RUN.

## Test plan
- **Basic draw.** Defaults; ROM returns (addr mod 7)+1; start with x_in=10, y_in=20.
  - Required: exactly 2048 writes.
  - First write in cycle 2 at (10,20), colour 1.
  - Last write in cycle 2049 at (41,83).
  - done in cycle 2050; busy high in cycles 1–2050.
- **Flip.** Same ROM, flip_h=1, origin (10,20).
  - Required: first write at (41,20) with ROM addr 0 colour 1.
  - Last write at (10,83).
- **Clipping.** Origin (300,200).
  - Required: exactly 20×40 = 800 writes, all with x<320 and y<240.
  - done still in cycle 2050.
- **Transparency.** ROM returns 0 for even addresses, 5 for odd.
  - Required: exactly 1024 writes, all with colour 5.
  - Repeat with erase=1, bg_colour=3'b010: 2048 writes, all with colour 2.
- **Start while busy.** Pulse start in cycles 50 and 2050.
  - Required: both are ignored; only one draw occurs.
  - A start in cycle 2051 is accepted.
- **Reset mid-draw.** Assert reset in cycle 100.
  - Required: from cycle 101, busy=0, writeEn=0, x_out=y_out=0, and done never pulses.
  - A following start draws normally from pixel 0.
